// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C target-side bit engine: FSM states, default address
// and the bus-level meaning of ACK/NACK.
package i2c_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ADDR      = 3'd1;
   localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
   localparam logic [2:0] ST_WR_BYTE   = 3'd3;
   localparam logic [2:0] ST_WR_ACK    = 3'd4;
   localparam logic [2:0] ST_RD_BYTE   = 3'd5;
   localparam logic [2:0] ST_RD_ACK    = 3'd6;
   localparam logic [2:0] ST_WAIT_STOP = 3'd7;

   localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h3C;

   localparam logic ACK_BIT  = 1'b0;
   localparam logic NACK_BIT = 1'b1;

   // Open-drain: a 0 on the bus is produced by enabling the pull-down.
   function automatic logic oe_for_bit(input logic b);
      return (b == 1'b0);
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus N-sample glitch filter for one bus line, with
// single-cycle rise/fall flags taken from the filtered level.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1;
   logic          sync2;
   logic          level_prev;
   logic [CW-1:0] cnt;

   // Everything resets high so an idle bus produces no spurious edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         level      <= 1'b1;
         level_prev <= 1'b1;
         cnt        <= '0;
      end else begin
         sync1      <= line_in;
         sync2      <= sync1;
         level_prev <= level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign rise = level & ~level_prev;
   assign fall = ~level & level_prev;

endmodule

// File: rtl/i2c_slave_bit_shift.sv
// I2C target bit engine: filtered SCL/SDA, START/STOP detection, 7-bit address match,
// write-byte reception with ACK and read-byte shifting. SCL is never stretched.
module i2c_slave_bit_shift
   import i2c_pkg::*;
#(
   parameter int         SYS_CLOCK  = 50_000_000,
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
   parameter int         FILTER_LEN = 3
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       i2c_sclk,
   inout  wire        i2c_sdat,
   output logic [7:0] Rx_DATA,
   output logic       Rx_Valid,
   input  logic [7:0] Tx_DATA,
   output logic       Tx_Req,
   output logic       Start_Det,
   output logic       Stop_Det,
   output logic       Master_Nack,
   output logic       Busy,
   output logic       Rw
);

   // A nonsensical configuration degrades to a single-sample filter.
   localparam int FLT = (SYS_CLOCK > 0 && FILTER_LEN >= 1) ? FILTER_LEN : 1;

   logic [1:0] raw_lines;
   logic [1:0] f_level;
   logic [1:0] f_rise;
   logic [1:0] f_fall;

   assign raw_lines = {i2c_sdat, i2c_sclk};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_filt
         i2c_line_filter #(.FILTER_LEN(FLT)) u_filt (
            .clk     (Clk),
            .rst     (Rst),
            .line_in (raw_lines[gi]),
            .level   (f_level[gi]),
            .rise    (f_rise[gi]),
            .fall    (f_fall[gi])
         );
      end
   endgenerate

   logic scl_f;
   logic sda_f;
   logic scl_rise;
   logic scl_fall;
   logic start_cond;
   logic stop_cond;

   assign scl_f      = f_level[0];
   assign sda_f      = f_level[1];
   assign scl_rise   = f_rise[0];
   assign scl_fall   = f_fall[0];
   assign start_cond = scl_f & f_fall[1];
   assign stop_cond  = scl_f & f_rise[1];

   logic [2:0] state;
   logic [3:0] bit_cnt;
   logic [7:0] shift;
   logic       sdat_oe;

   assign i2c_sdat = sdat_oe ? 1'b0 : 1'bz;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         sdat_oe     <= 1'b0;
         Rx_DATA     <= '0;
         Rx_Valid    <= 1'b0;
         Tx_Req      <= 1'b0;
         Start_Det   <= 1'b0;
         Stop_Det    <= 1'b0;
         Master_Nack <= 1'b0;
         Busy        <= 1'b0;
         Rw          <= 1'b0;
      end else begin
         Rx_Valid    <= 1'b0;
         Tx_Req      <= 1'b0;
         Start_Det   <= 1'b0;
         Stop_Det    <= 1'b0;
         Master_Nack <= 1'b0;
         if (stop_cond) begin
            state    <= ST_IDLE;
            sdat_oe  <= 1'b0;
            Busy     <= 1'b0;
            Stop_Det <= 1'b1;
         end else if (start_cond) begin
            state     <= ST_ADDR;
            bit_cnt   <= '0;
            sdat_oe   <= 1'b0;
            Busy      <= 1'b0;
            Start_Det <= 1'b1;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     if (shift[7:1] == SLAVE_ADDR) begin
                        sdat_oe <= oe_for_bit(ACK_BIT);
                        Rw      <= shift[0];
                        Busy    <= 1'b1;
                        state   <= ST_ADDR_ACK;
                     end else begin
                        state <= ST_WAIT_STOP;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  if (scl_rise && Rw) begin
                     Tx_Req <= 1'b1;
                  end else if (scl_fall) begin
                     if (Rw) begin
                        shift   <= Tx_DATA;
                        sdat_oe <= oe_for_bit(Tx_DATA[7]);
                        bit_cnt <= 4'd1;
                        state   <= ST_RD_BYTE;
                     end else begin
                        sdat_oe <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_WR_BYTE;
                     end
                  end
               end
               ST_WR_BYTE: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        Rx_DATA  <= {shift[6:0], sda_f};
                        Rx_Valid <= 1'b1;
                     end
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     sdat_oe <= oe_for_bit(ACK_BIT);
                     state   <= ST_WR_ACK;
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall) begin
                     sdat_oe <= 1'b0;
                     bit_cnt <= '0;
                     state   <= ST_WR_BYTE;
                  end
               end
               // bit_cnt counts bits already presented; shift[7] is the bit on the bus.
               ST_RD_BYTE: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sdat_oe <= 1'b0;
                        state   <= ST_RD_ACK;
                     end else begin
                        sdat_oe <= oe_for_bit(shift[6]);
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_f == NACK_BIT) begin
                        Master_Nack <= 1'b1;
                        Busy        <= 1'b0;
                        state       <= ST_WAIT_STOP;
                     end else begin
                        Tx_Req <= 1'b1;
                     end
                  end else if (scl_fall) begin
                     shift   <= Tx_DATA;
                     sdat_oe <= oe_for_bit(Tx_DATA[7]);
                     bit_cnt <= 4'd1;
                     state   <= ST_RD_BYTE;
                  end
               end
               default: begin
                  sdat_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_bit_shift.sv
// Directed bench: a behavioural I2C master drives the DUT over a pulled-up SDA line;
// every test task checks its own results against hand-computed values.
module tb_i2c_slave_bit_shift;

   localparam int Q = 40;  // Clk cycles per quarter SCL period

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       scl = 1'b1;
   logic       master_low = 1'b0;
   logic [7:0] Tx_DATA = 8'h00;
   wire        sda;
   logic [7:0] Rx_DATA;
   logic       Rx_Valid, Tx_Req, Start_Det, Stop_Det, Master_Nack, Busy, Rw;

   assign sda = master_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #10 Clk = ~Clk;

   i2c_slave_bit_shift dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .i2c_sclk    (scl),
      .i2c_sdat    (sda),
      .Rx_DATA     (Rx_DATA),
      .Rx_Valid    (Rx_Valid),
      .Tx_DATA     (Tx_DATA),
      .Tx_Req      (Tx_Req),
      .Start_Det   (Start_Det),
      .Stop_Det    (Stop_Det),
      .Master_Nack (Master_Nack),
      .Busy        (Busy),
      .Rw          (Rw)
   );

   int checks = 0;
   int errors = 0;

   int n_rx = 0, n_txreq = 0, n_start = 0, n_stop = 0, n_nack = 0, n_long = 0, n_dut_low = 0;
   logic [7:0] rx_log [0:31];
   logic [4:0] pulses;
   logic [4:0] prev_pulses = 5'b0;

   assign pulses = {Rx_Valid, Tx_Req, Start_Det, Stop_Det, Master_Nack};

   always @(negedge Clk) begin
      if (Rx_Valid && n_rx < 32) begin
         rx_log[n_rx] = Rx_DATA;
         n_rx++;
      end
      if (Tx_Req) n_txreq++;
      if (Start_Det) n_start++;
      if (Stop_Det) n_stop++;
      if (Master_Nack) n_nack++;
      if ((pulses & prev_pulses) != 5'b0) n_long++;
      prev_pulses = pulses;
      if (!master_low && !Rst && sda === 1'b0) n_dut_low++;
   end

   task automatic wait_q();
      repeat (Q) @(posedge Clk);
      #1;
   endtask

   task automatic clock_bit(input logic drive_low, output logic sampled);
      master_low = drive_low;
      wait_q();
      scl = 1'b1;
      wait_q();
      sampled = sda;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic bus_start();
      master_low = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      master_low = 1'b1;
      wait_q();
      scl = 1'b0;
      wait_q();
   endtask

   task automatic bus_stop();
      master_low = 1'b1;
      wait_q();
      scl = 1'b1;
      wait_q();
      master_low = 1'b0;
      wait_q();
   endtask

   // glitch_idx selects a bit preceded by a short SCL spike; any value outside 0..7 means none.
   task automatic send_byte(input logic [7:0] b, input int glitch_idx, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         if (i == glitch_idx) begin
            master_low = ~b[i];
            repeat (Q / 2) @(posedge Clk);
            #1;
            scl = 1'b1;
            repeat (2) @(posedge Clk);
            #1;
            scl = 1'b0;
            repeat (Q / 2) @(posedge Clk);
            #1;
         end
         clock_bit(~b[i], s);
      end
      clock_bit(1'b0, ack);
   endtask

   task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                            output logic [7:0] data);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b0, s);
         data[i] = s;
      end
      Tx_DATA = next_tx;
      clock_bit(master_ack, s);
      master_low = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (10) @(posedge Clk);
      #1;
      checks++;
      if ({Rx_DATA, Rx_Valid, Tx_Req, Start_Det, Stop_Det, Master_Nack, Busy, Rw} !== 15'h0) begin
         errors++;
         $display("FAIL reset_outputs: got Rx_DATA=%h pulses=%b Busy=%b Rw=%b, required all 0",
                  Rx_DATA, pulses, Busy, Rw);
      end
      checks++;
      if (sda !== 1'b1) begin
         errors++;
         $display("FAIL reset_sda: got %b required 1", sda);
      end
      Rst = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      $display("test_reset done");
   endtask

   task automatic test_write();
      int rx0 = n_rx, st0 = n_start, sp0 = n_stop, lg0 = n_long;
      logic ack;
      bus_start();
      send_byte(8'h78, 99, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b required 0", ack); end
      checks++;
      if (Busy !== 1'b1 || Rw !== 1'b0) begin
         errors++;
         $display("FAIL wr_busy_rw: got Busy=%b Rw=%b required Busy=1 Rw=0", Busy, Rw);
      end
      send_byte(8'hA5, 99, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL wr_data1_ack: got %b required 0", ack); end
      send_byte(8'h5A, 99, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL wr_data2_ack: got %b required 0", ack); end
      bus_stop();
      wait_q();
      checks++;
      if (n_rx - rx0 != 2 || rx_log[rx0] !== 8'hA5 || rx_log[rx0 + 1] !== 8'h5A) begin
         errors++;
         $display("FAIL wr_rx_bytes: got count=%0d first=%h second=%h required 2 A5 5A",
                  n_rx - rx0, rx_log[rx0], rx_log[rx0 + 1]);
      end
      checks++;
      if (n_start - st0 != 1 || n_stop - sp0 != 1) begin
         errors++;
         $display("FAIL wr_start_stop: got start=%0d stop=%0d required 1 1", n_start - st0, n_stop - sp0);
      end
      checks++;
      if (Busy !== 1'b0 || Rx_DATA !== 8'h5A) begin
         errors++;
         $display("FAIL wr_after_stop: got Busy=%b Rx_DATA=%h required 0 5A", Busy, Rx_DATA);
      end
      checks++;
      if (n_long != lg0) begin
         errors++;
         $display("FAIL pulse_width: got %0d multi-cycle pulses required 0", n_long - lg0);
      end
      $display("test_write done");
   endtask

   task automatic test_mismatch();
      int rx0 = n_rx, dl0 = n_dut_low;
      logic ack1, ack2;
      bus_start();
      send_byte(8'hA4, 99, ack1);
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b required 0", Busy); end
      send_byte(8'h11, 99, ack2);
      bus_stop();
      wait_q();
      checks++;
      if (ack1 !== 1'b1 || ack2 !== 1'b1) begin
         errors++;
         $display("FAIL mm_nack: got acks %b %b required 1 1", ack1, ack2);
      end
      checks++;
      if (n_dut_low != dl0 || n_rx != rx0) begin
         errors++;
         $display("FAIL mm_silent: got dut_low_cycles=%0d rx=%0d required 0 0", n_dut_low - dl0, n_rx - rx0);
      end
      $display("test_mismatch done");
   endtask

   task automatic test_read();
      int tr0 = n_txreq, nk0 = n_nack;
      logic ack;
      logic [7:0] d1, d2;
      Tx_DATA = 8'hC3;
      bus_start();
      send_byte(8'h79, 99, ack);
      checks++;
      if (ack !== 1'b0 || Rw !== 1'b1 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL rd_addr: got ack=%b Rw=%b Busy=%b required 0 1 1", ack, Rw, Busy);
      end
      read_byte(1'b1, 8'h81, d1);
      read_byte(1'b0, 8'h00, d2);
      checks++;
      if (d1 !== 8'hC3 || d2 !== 8'h81) begin
         errors++;
         $display("FAIL rd_data: got %h %h required C3 81", d1, d2);
      end
      checks++;
      if (sda !== 1'b1 || Busy !== 1'b0) begin
         errors++;
         $display("FAIL rd_release: got sda=%b Busy=%b required 1 0", sda, Busy);
      end
      checks++;
      if (n_txreq - tr0 != 2 || n_nack - nk0 != 1) begin
         errors++;
         $display("FAIL rd_pulses: got Tx_Req=%0d Master_Nack=%0d required 2 1", n_txreq - tr0, n_nack - nk0);
      end
      bus_stop();
      wait_q();
      $display("test_read done");
   endtask

   task automatic test_repeated_start();
      int rx0 = n_rx, st0 = n_start;
      logic ack;
      logic rw_wr;
      logic [7:0] d;
      Tx_DATA = 8'h5E;
      bus_start();
      send_byte(8'h78, 99, ack);
      rw_wr = Rw;
      send_byte(8'h10, 99, ack);
      bus_start();
      send_byte(8'h79, 99, ack);
      checks++;
      if (rw_wr !== 1'b0 || Rw !== 1'b1 || ack !== 1'b0) begin
         errors++;
         $display("FAIL sr_rw: got Rw %b->%b ack=%b required 0->1 ack=0", rw_wr, Rw, ack);
      end
      read_byte(1'b0, 8'h00, d);
      bus_stop();
      wait_q();
      checks++;
      if (d !== 8'h5E) begin errors++; $display("FAIL sr_read: got %h required 5E", d); end
      checks++;
      if (n_rx - rx0 != 1 || rx_log[rx0] !== 8'h10 || n_start - st0 != 2) begin
         errors++;
         $display("FAIL sr_counts: got rx=%0d byte=%h starts=%0d required 1 10 2",
                  n_rx - rx0, rx_log[rx0], n_start - st0);
      end
      $display("test_repeated_start done");
   endtask

   task automatic test_glitch();
      int rx0 = n_rx;
      logic ack;
      bus_start();
      send_byte(8'h78, 99, ack);
      send_byte(8'h96, 4, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL gl_ack: got %b required 0", ack); end
      bus_stop();
      wait_q();
      checks++;
      if (n_rx - rx0 != 1 || rx_log[rx0] !== 8'h96) begin
         errors++;
         $display("FAIL gl_byte: got count=%0d byte=%h required 1 96", n_rx - rx0, rx_log[rx0]);
      end
      $display("test_glitch done");
   endtask

   task automatic test_reset_mid();
      logic s;
      logic [7:0] a;
      a = 8'h78;
      bus_start();
      for (int i = 7; i >= 0; i--) clock_bit(~a[i], s);
      master_low = 1'b0;
      wait_q();
      scl = 1'b1;
      wait_q();
      checks++;
      if (sda !== 1'b0) begin errors++; $display("FAIL rm_ack_driven: got %b required 0", sda); end
      Rst = 1'b1;
      #1;
      checks++;
      if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda_release: got %b required 1", sda); end
      checks++;
      if ({Rx_DATA, Busy, Rw} !== 10'h0) begin
         errors++;
         $display("FAIL rm_outputs: got Rx_DATA=%h Busy=%b Rw=%b required 00 0 0", Rx_DATA, Busy, Rw);
      end
      repeat (5) @(posedge Clk);
      #1;
      Rst = 1'b0;
      wait_q();
      scl = 1'b0;
      wait_q();
      bus_start();
      send_byte(8'h78, 99, s);
      checks++;
      if (s !== 1'b0 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL rm_recover: got ack=%b Busy=%b required 0 1", s, Busy);
      end
      bus_stop();
      wait_q();
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_write();
      test_mismatch();
      test_read();
      test_repeated_start();
      test_glitch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_bit_shift.md
# i2c_slave_bit_shift

I2C target-side bit engine: it responds to an external I2C master on the same two-wire bus our master-side shifter drives. It oversamples SCL/SDA on the system clock, detects START/repeated-START/STOP, matches a 7-bit address, ACKs and receives write bytes, and shifts out read bytes supplied by user logic. It sits between the bus pins and register-file or bridge logic. It never stretches SCL.

## Interface
- SYS_CLOCK, 50_000_000: system clock frequency (Hz); informational, sets bench timing.
- SLAVE_ADDR, 7'h3C: 7-bit address this block responds to.
- FILTER_LEN, 3: number of consecutive equal samples required before a synchronized line changes its filtered value (glitch filter, ≥1).

Ports:
- Clk  input  1  system clock.
- Rst  input  1  asynchronous, active-high reset.
- i2c_sclk  input  1  bus SCL (block never drives it).
- i2c_sdat  inout  1  bus SDA, open-drain: driven 0 when sdat_oe=1, else high-Z.
- Rx_DATA  output  8  last received write byte, MSB first.
- Rx_Valid  output  1  1-cycle pulse: Rx_DATA updated.
- Tx_DATA  input  8  next read byte from user logic.
- Tx_Req  output  1  1-cycle pulse: user must present the next read byte on Tx_DATA.
- Start_Det  output  1  1-cycle pulse on START or repeated START.
- Stop_Det  output  1  1-cycle pulse on STOP.
- Master_Nack  output  1  1-cycle pulse: master NACKed a read byte.
- Busy  output  1  high from addressed-ACK until STOP/START/NACK.
- Rw  output  1  R/W bit of last matched address (1 = read).

## Operation
- Each line: 2-flop synchronizer then FILTER_LEN glitch filter -> scl_f, sda_f; edges derived from registered previous values.
- START: sda_f falls while scl_f high. STOP: sda_f rises while scl_f high. Both override every state: START -> ADDR (bit counter cleared, SDA released); STOP -> IDLE (SDA released, Busy=0).
- Data sampled on scl_f rising edge, MSB first; SDA driven/released only on scl_f falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- ADDR: 8 bits shifted in. At next SCL fall: match -> drive 0 (ACK), Rw latched, Busy=1, go ADDR_ACK; mismatch -> WAIT_STOP, SDA never driven. General call not supported.
- ADDR_ACK: on ACK-slot SCL rise with Rw=1, pulse Tx_Req. At following SCL fall: Rw=0 -> release, WR_BYTE; Rw=1 -> load Tx_DATA into shift reg, drive bit 7, RD_BYTE.
- WR_BYTE: after 8th rise, Rx_DATA <= byte, Rx_Valid pulse; at next fall drive ACK, WR_ACK; at following fall release, WR_BYTE. Every write byte is ACKed.
- RD_BYTE: each fall presents next bit (0 -> drive, 1 -> release); after 8th bit, release at fall, RD_ACK.
- RD_ACK: sample at SCL rise; 0 -> pulse Tx_Req, at next fall load Tx_DATA and drive bit 7, RD_BYTE; 1 -> Master_Nack pulse, Busy=0, WAIT_STOP.
- WAIT_STOP: SDA released; leaves only on START/STOP.

## Timing
- Pin-to-filtered latency: 2 + FILTER_LEN Clk cycles; SDA change after SCL fall follows same latency plus 1 cycle (acts as hold time).
- Rx_Valid, Tx_Req, Start_Det, Stop_Det, Master_Nack: exactly 1 Clk high, registered.
- Tx_DATA sampled at the SCL fall ending the ACK slot (≥ half an SCL period after Tx_Req); must be stable then.
- Reset values: Rx_DATA 0, all pulses 0, Busy 0, Rw 0, sdat_oe 0 (SDA released), state IDLE, filters initialized to 1 (bus idle). Rst mid-transfer releases SDA asynchronously.
- Minimum supported ratio: Clk ≥ 20× SCL with FILTER_LEN=3 (400 kHz at 50 MHz = 125×).

## Structure
- Shared package i2c_pkg: state encodings, default SLAVE_ADDR, ACK/NACK bit constants.
- Sub-module i2c_line_filter (synchronizer + glitch filter + rise/fall flags), instantiated for SCL and SDA.

## Test plan
- START, 0x78, 0xA5, 0x5A, STOP -> ACK on 3 slots; Rx_Valid twice with 0xA5, 0x5A; Rw=0; Stop_Det once; Busy low after STOP.
- START, 0xA4 (addr 0x52) , 0x11, STOP -> SDA never driven low by DUT, no Rx_Valid, Busy stays 0.
- START, 0x79; Tx_DATA 0xC3 then 0x81; master ACKs first, NACKs second -> bus reads 0xC3, 0x81; Tx_Req twice; Master_Nack once; SDA released after NACK.
- START, 0x78, 0x10, Sr, 0x79, read 1 byte, NACK, STOP -> Rx_Valid 0x10, Start_Det twice, Rw toggles 0->1, correct read byte.
- SCL glitch shorter than FILTER_LEN cycles mid-byte -> no extra bit shifted, byte received intact.
- Assert Rst while DUT drives ACK -> SDA released immediately, all outputs at reset values, next START/0x78 handled normally.
